hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage CPU. It produces the 2-bit ForwardA/ForwardB selects that steer the EX-stage operand muxes. It sequences the pipeline registers through load-use stalls, taken-branch flushes and multi-cycle data-memory waits, and flags data-memory accesses that time out. It sits beside the ID/EX, EX/MEM and MEM/WB registers and drives their write-enable, bubble and flush controls.

## Interface
- MEM_TIMEOUT, 255: number of freeze cycles before `mem_timeout` is raised; must be ≥1.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_rs, id_rt  in  5  source registers of the instruction in ID
- ex_rs, ex_rt  in  5  source registers of the instruction in EX
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  instruction in EX is a load
- mem_rd  in  5  destination register of the instruction in EX/MEM
- mem_reg_write  in  1  EX/MEM instruction writes the register file
- wb_rd  in  5  destination register of the instruction in MEM/WB
- wb_reg_write  in  1  MEM/WB instruction writes the register file
- mem_access  in  1  instruction in MEM is a load or store
- dmem_ready  in  1  data memory completes the access this cycle
- branch_taken  in  1  branch resolved taken in EX
- forward_a, forward_b  out  2  operand selects: 00 register file, 10 EX/MEM ALU result, 01 MEM/WB write data
- pc_write  out  1  PC may update
- ifid_write  out  1  IF/ID may load
- ifid_flush  out  1  IF/ID loads a NOP
- idex_bubble  out  1  ID/EX loads a NOP
- pipe_freeze  out  1  hold EX/MEM and MEM/WB
- mem_timeout  out  1  sticky: a memory wait exceeded MEM_TIMEOUT

## Operation
- Forwarding (combinational, same logic for rs→a and rt→b):
  - Select 10 if `mem_reg_write`, `mem_rd`≠0 and `mem_rd`==ex_rs/ex_rt.
  - Otherwise select 01 if `wb_reg_write`, `wb_rd`≠0 and `wb_rd`==ex_rs/ex_rt.
  - Otherwise select 00.
  - EX/MEM has priority over MEM/WB. Encoding 11 is never driven.
- FSM states:
  - RUN → MWAIT when `mem_access` && !`dmem_ready`.
  - MWAIT → RUN when `dmem_ready`=1.
  - rst → RUN from any state.
- Freeze: asserted in the same cycle the condition appears (RUN with `mem_access` && !`dmem_ready`), and in every MWAIT cycle where `dmem_ready`=0. While frozen: `pipe_freeze`=1, `pc_write`=0, `ifid_write`=0, `idex_bubble`=0, `ifid_flush`=0.
- Flush (not frozen, `branch_taken`=1): `ifid_flush`=1, `idex_bubble`=1, `pc_write`=1 (PC loads the target).
- Load-use (not frozen, no flush): a load-use hazard is `ex_mem_read`, `ex_rd`≠0 and `ex_rd`∈{`id_rs`,`id_rt`}. Response: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1.
- Event priority: freeze > flush > load-use > normal. A branch or load-use hazard that arrives during a freeze is held in the frozen registers and handled after the freeze releases.
- Normal: `pc_write`=`ifid_write`=1, all other controls 0.
- Wait counter `wait_cnt`, width $clog2(MEM_TIMEOUT+1):
  - Cleared in RUN.
  - Increments each MWAIT cycle and saturates at MEM_TIMEOUT.
  - `mem_timeout` is set when `wait_cnt` reaches MEM_TIMEOUT while `dmem_ready`=0.
  - `mem_timeout` clears only on rst.

## Timing
- Forward selects and stall/flush controls are zero-latency: they are valid in the same cycle as their inputs.
- Load-use inserts exactly 1 bubble. The following cycle the forward select from MEM/WB is 01.
- A memory wait of N cycles with `dmem_ready` low freezes the pipeline for exactly N cycles. The `dmem_ready`=1 cycle is not frozen.
- `mem_timeout` rises on the clock edge after the cycle that has `wait_cnt`==MEM_TIMEOUT and `dmem_ready`=0.
- During a rst cycle, outputs are forced to: forward 00, `pc_write`=1, `ifid_write`=1, all other controls 0.
- Next-cycle (registered) values after reset: state RUN, `wait_cnt` 0, `mem_timeout` 0, counters 0.
- Reset asserted in MWAIT aborts the wait. The freeze drops in the reset cycle itself.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds outputs `stall_cycles` (out 32) and `flush_count` (out 32), both reset to 0 and wrapping modulo 2^32.
  - `stall_cycles` increments every non-reset cycle with `pc_write`=0.
  - `flush_count` increments every cycle with `ifid_flush`=1.
- HAZARD_PERF_CNT_EN undefined: these ports and registers are absent. All other behaviour is identical.

## Structure
- Shared package `hazard_pkg`:
  - `fwd_sel_t` with FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01
  - `hz_state_t` {RUN, MWAIT}
  - REG_ZERO=5'd0
- Sub-module `fwd_sel_unit` (one source register → 2-bit select), instantiated twice, once for rs and once for rt.

## Test plan
- `ex_rs`=3, `mem_rd`=3 with `mem_reg_write`=1, and `wb_rd`=3 with `wb_reg_write`=1 → `forward_a`=10. Set `mem_reg_write`=0 → `forward_a`=01. Set `mem_rd`=`wb_rd`=0 → `forward_a`=00.
- Load to `ex_rd`=5 with `ex_mem_read`=1 and `id_rt`=5 → one cycle of `pc_write`=0, `ifid_write`=0, `idex_bubble`=1; next cycle `forward_b`=01 and no stall.
- `mem_access`=1 with `dmem_ready` low for 3 cycles → `pipe_freeze`=1 for exactly those 3 cycles; freeze drops in the ready cycle; state returns to RUN.
- MEM_TIMEOUT=4, `dmem_ready` held 0 → `mem_timeout`=1 after the 5th freeze cycle and remains 1 after `dmem_ready`=1 until rst.
- `branch_taken`=1 in the same cycle as a load-use hazard → `ifid_flush`=1, `idex_bubble`=1, `pc_write`=1. `branch_taken` during a freeze → no flush until the freeze ends.
- rst pulsed while in MWAIT → the next cycle is RUN with all controls normal; with HAZARD_PERF_CNT_EN, `stall_cycles`=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   fwd_sel_t  : EX operand-mux select encoding
//   hz_state_t : controller FSM states
//   REG_ZERO   : architectural zero register (never a forwarding/hazard source)
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_MEMWB = 2'b01,
      FWD_EXMEM = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      RUN   = 1'b0,
      MWAIT = 1'b1
   } hz_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundles every hazard-controller signal except clk/rst.
//   slave  modport : seen by hazard_ctrl (pipeline status in, controls out)
//   master modport : seen by the pipeline / bench (drives status, reads controls)
// Optional macro HAZARD_PERF_CNT_EN adds stall_cycles / flush_count.
interface hazard_ctrl_if;

   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [4:0]  ex_rs;
   logic [4:0]  ex_rt;
   logic [4:0]  ex_rd;
   logic        ex_mem_read;
   logic [4:0]  mem_rd;
   logic        mem_reg_write;
   logic [4:0]  wb_rd;
   logic        wb_reg_write;
   logic        mem_access;
   logic        dmem_ready;
   logic        branch_taken;
   logic [1:0]  forward_a;
   logic [1:0]  forward_b;
   logic        pc_write;
   logic        ifid_write;
   logic        ifid_flush;
   logic        idex_bubble;
   logic        pipe_freeze;
   logic        mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;
`endif

   modport slave (
      input  id_rs, id_rt, ex_rs, ex_rt, ex_rd, ex_mem_read,
             mem_rd, mem_reg_write, wb_rd, wb_reg_write,
             mem_access, dmem_ready, branch_taken,
      output forward_a, forward_b, pc_write, ifid_write, ifid_flush,
             idex_bubble, pipe_freeze, mem_timeout
`ifdef HAZARD_PERF_CNT_EN
      , output stall_cycles, flush_count
`endif
   );

   modport master (
      output id_rs, id_rt, ex_rs, ex_rt, ex_rd, ex_mem_read,
             mem_rd, mem_reg_write, wb_rd, wb_reg_write,
             mem_access, dmem_ready, branch_taken,
      input  forward_a, forward_b, pc_write, ifid_write, ifid_flush,
             idex_bubble, pipe_freeze, mem_timeout
`ifdef HAZARD_PERF_CNT_EN
      , input stall_cycles, flush_count
`endif
   );

endinterface

// File: rtl/fwd_sel_unit.sv
// fwd_sel_unit: forwarding select for one EX source register.
//   src                    : source register of the EX instruction
//   mem_rd / mem_reg_write : EX/MEM destination and write flag
//   wb_rd  / wb_reg_write  : MEM/WB destination and write flag
//   sel                    : FWD_EXMEM, FWD_MEMWB or FWD_RF (11 never produced)
module fwd_sel_unit
   import hazard_pkg::*;
(
   input  logic [4:0] src,
   input  logic [4:0] mem_rd,
   input  logic       mem_reg_write,
   input  logic [4:0] wb_rd,
   input  logic       wb_reg_write,
   output fwd_sel_t   sel
);

   // EX/MEM holds the younger result, so it wins over MEM/WB.
   always_comb begin
      sel = FWD_RF;
      if (mem_reg_write && (mem_rd != REG_ZERO) && (mem_rd == src)) begin
         sel = FWD_EXMEM;
      end else if (wb_reg_write && (wb_rd != REG_ZERO) && (wb_rd == src)) begin
         sel = FWD_MEMWB;
      end else begin
         sel = FWD_RF;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: five-stage pipeline hazard controller.
//   clk, rst : clock, synchronous active-high reset
//   hz       : hazard_ctrl_if.slave (register ids, load/branch/memory status in;
//              forward selects, PC/IF/ID/ID/EX/freeze controls, mem_timeout out)
// Parameter MEM_TIMEOUT (>=1): freeze cycles after which mem_timeout latches.
// Optional macro HAZARD_PERF_CNT_EN adds stall_cycles and flush_count counters.
// Controls are combinational (same-cycle); state, wait_cnt and mem_timeout are
// registered. While rst is high every output reads as the "normal" pattern.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input logic          clk,
   input logic          rst,
   hazard_ctrl_if.slave hz
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   hz_state_t        state;
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_flag;

   fwd_sel_t fwd_a_raw;
   fwd_sel_t fwd_b_raw;
   logic     freeze;
   logic     load_use;
   logic     pc_write;
   logic     ifid_write;
   logic     ifid_flush;
   logic     idex_bubble;

   fwd_sel_unit u_fwd_a (
      .src           (hz.ex_rs),
      .mem_rd        (hz.mem_rd),
      .mem_reg_write (hz.mem_reg_write),
      .wb_rd         (hz.wb_rd),
      .wb_reg_write  (hz.wb_reg_write),
      .sel           (fwd_a_raw)
   );

   fwd_sel_unit u_fwd_b (
      .src           (hz.ex_rt),
      .mem_rd        (hz.mem_rd),
      .mem_reg_write (hz.mem_reg_write),
      .wb_rd         (hz.wb_rd),
      .wb_reg_write  (hz.wb_reg_write),
      .sel           (fwd_b_raw)
   );

   // Freeze starts in the cycle the unready access shows up, before the FSM moves.
   always_comb begin
      freeze = 1'b0;
      if (rst) begin
         freeze = 1'b0;
      end else if (state == MWAIT) begin
         freeze = !hz.dmem_ready;
      end else begin
         freeze = hz.mem_access && !hz.dmem_ready;
      end
   end

   // Load-use: load in EX writes a register the ID instruction reads.
   always_comb begin
      load_use = hz.ex_mem_read && (hz.ex_rd != REG_ZERO) &&
                 ((hz.ex_rd == hz.id_rs) || (hz.ex_rd == hz.id_rt));
   end

   // Pipeline control priority: freeze > flush > load-use > normal.
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (rst) begin
         pc_write = 1'b1;
      end else if (freeze) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end else if (hz.branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (load_use) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
      end else begin
         pc_write = 1'b1;
      end
   end

   // FSM and wait counter; wait_cnt equals the number of freeze cycles already
   // elapsed in the current wait, so it reads k in the k-th MWAIT cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         wait_cnt     <= '0;
         timeout_flag <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (hz.mem_access && !hz.dmem_ready) begin
                  state    <= MWAIT;
                  wait_cnt <= CNT_ONE;
               end else begin
                  wait_cnt <= '0;
               end
            end
            MWAIT: begin
               if (hz.dmem_ready) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else begin
                  if (wait_cnt < CNT_MAX) begin
                     wait_cnt <= wait_cnt + CNT_ONE;
                  end
                  if (wait_cnt == CNT_MAX) begin
                     timeout_flag <= 1'b1;
                  end
               end
            end
            default: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;

   // Free-running performance counters, wrapping naturally at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= 32'd0;
         flush_count  <= 32'd0;
      end else begin
         if (!pc_write) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (ifid_flush) begin
            flush_count <= flush_count + 32'd1;
         end
      end
   end

   assign hz.stall_cycles = stall_cycles;
   assign hz.flush_count  = flush_count;
`endif

   assign hz.forward_a   = rst ? FWD_RF : fwd_a_raw;
   assign hz.forward_b   = rst ? FWD_RF : fwd_b_raw;
   assign hz.pc_write    = pc_write;
   assign hz.ifid_write  = ifid_write;
   assign hz.ifid_flush  = ifid_flush;
   assign hz.idex_bubble = idex_bubble;
   assign hz.pipe_freeze = freeze;
   assign hz.mem_timeout = timeout_flag && !rst;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_hazard_ctrl;
   import hazard_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   compared   = 0;
   int   mismatched = 0;

   hazard_ctrl_if hz ();

   hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      hz.id_rs = 5'd0; hz.id_rt = 5'd0;
      hz.ex_rs = 5'd0; hz.ex_rt = 5'd0; hz.ex_rd = 5'd0;
      hz.ex_mem_read = 1'b0;
      hz.mem_rd = 5'd0; hz.mem_reg_write = 1'b0;
      hz.wb_rd = 5'd0;  hz.wb_reg_write = 1'b0;
      hz.mem_access = 1'b0; hz.dmem_ready = 1'b0;
      hz.branch_taken = 1'b0;
   endtask

   initial begin
      // ---- reset cycle: outputs forced normal despite hazardous inputs ----
      idle_inputs();
      rst = 1'b1;
      hz.ex_rs = 5'd3; hz.mem_rd = 5'd3; hz.mem_reg_write = 1'b1;
      hz.mem_access = 1'b1; hz.dmem_ready = 1'b0;
      #1;
      chk("rst_fwd_a", hz.forward_a, 2'b00);
      chk("rst_pc_write", hz.pc_write, 1'b1);
      chk("rst_ifid_write", hz.ifid_write, 1'b1);
      chk("rst_freeze", hz.pipe_freeze, 1'b0);
      chk("rst_bubble", hz.idex_bubble, 1'b0);
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      idle_inputs();
      #1;
      chk("post_rst_state", dut.state, RUN);
      chk("post_rst_wait_cnt", dut.wait_cnt, 3'd0);
      chk("post_rst_timeout", hz.mem_timeout, 1'b0);
      chk("post_rst_pc_write", hz.pc_write, 1'b1);

      // ---- forwarding priority ----
      hz.ex_rs = 5'd3; hz.mem_rd = 5'd3; hz.mem_reg_write = 1'b1;
      hz.wb_rd = 5'd3; hz.wb_reg_write = 1'b1; hz.ex_rt = 5'd7;
      #1;
      chk("fwd_a_exmem", hz.forward_a, 2'b10);
      chk("fwd_b_none", hz.forward_b, 2'b00);
      hz.mem_reg_write = 1'b0;
      #1;
      chk("fwd_a_memwb", hz.forward_a, 2'b01);
      hz.mem_reg_write = 1'b1; hz.mem_rd = 5'd0; hz.wb_rd = 5'd0;
      hz.ex_rs = 5'd0;
      #1;
      chk("fwd_a_zero_reg", hz.forward_a, 2'b00);
      hz.ex_rt = 5'd9; hz.wb_rd = 5'd9; hz.wb_reg_write = 1'b1;
      #1;
      chk("fwd_b_memwb", hz.forward_b, 2'b01);

      // ---- load-use: one bubble, then MEM/WB forward ----
      next_cycle();
      idle_inputs();
      hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5; hz.id_rt = 5'd5;
      #1;
      chk("lu_pc_write", hz.pc_write, 1'b0);
      chk("lu_ifid_write", hz.ifid_write, 1'b0);
      chk("lu_bubble", hz.idex_bubble, 1'b1);
      next_cycle();
      idle_inputs();
      hz.ex_rt = 5'd5; hz.wb_rd = 5'd5; hz.wb_reg_write = 1'b1;
      #1;
      chk("lu_next_fwd_b", hz.forward_b, 2'b01);
      chk("lu_next_pc_write", hz.pc_write, 1'b1);
      chk("lu_next_bubble", hz.idex_bubble, 1'b0);

      // ---- 3-cycle memory wait, branch arriving mid-freeze ----
      next_cycle();
      idle_inputs();
      hz.mem_access = 1'b1; hz.dmem_ready = 1'b0;
      #1;
      chk("mw1_freeze", hz.pipe_freeze, 1'b1);
      chk("mw1_pc_write", hz.pc_write, 1'b0);
      chk("mw1_ifid_write", hz.ifid_write, 1'b0);
      chk("mw1_bubble", hz.idex_bubble, 1'b0);
      next_cycle();
      hz.branch_taken = 1'b1;
      #1;
      chk("mw2_state", dut.state, MWAIT);
      chk("mw2_freeze", hz.pipe_freeze, 1'b1);
      chk("mw2_no_flush", hz.ifid_flush, 1'b0);
      next_cycle();
      #1;
      chk("mw3_freeze", hz.pipe_freeze, 1'b1);
      chk("mw3_wait_cnt", dut.wait_cnt, 3'd2);
      next_cycle();
      hz.dmem_ready = 1'b1;
      #1;
      chk("mw_ready_freeze", hz.pipe_freeze, 1'b0);
      chk("mw_ready_flush", hz.ifid_flush, 1'b1);
      chk("mw_ready_pc_write", hz.pc_write, 1'b1);
      next_cycle();
      idle_inputs();
      #1;
      chk("mw_done_state", dut.state, RUN);
      chk("mw_done_freeze", hz.pipe_freeze, 1'b0);
      chk("mw_short_no_timeout", hz.mem_timeout, 1'b0);

      // ---- branch beats load-use ----
      hz.branch_taken = 1'b1;
      hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5; hz.id_rs = 5'd5;
      #1;
      chk("br_lu_flush", hz.ifid_flush, 1'b1);
      chk("br_lu_bubble", hz.idex_bubble, 1'b1);
      chk("br_lu_pc_write", hz.pc_write, 1'b1);

      // ---- timeout: 5 freeze cycles with MEM_TIMEOUT=4 ----
      next_cycle();
      idle_inputs();
      hz.mem_access = 1'b1; hz.dmem_ready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         #1;
         chk("to_freeze", hz.pipe_freeze, 1'b1);
         chk("to_early_flag", hz.mem_timeout, 1'b0);
         next_cycle();
      end
      #1;
      chk("to_5th_wait_cnt", dut.wait_cnt, 3'd4);
      chk("to_5th_flag_low", hz.mem_timeout, 1'b0);
      next_cycle();
      #1;
      chk("to_flag_set", hz.mem_timeout, 1'b1);
      hz.dmem_ready = 1'b1;
      next_cycle();
      idle_inputs();
      #1;
      chk("to_flag_sticky", hz.mem_timeout, 1'b1);
      chk("to_state_run", dut.state, RUN);

      // ---- reset during MWAIT ----
      hz.mem_access = 1'b1; hz.dmem_ready = 1'b0;
      next_cycle();
      #1;
      chk("rw_freeze_before", hz.pipe_freeze, 1'b1);
      next_cycle();
      rst = 1'b1;
      #1;
      chk("rw_rst_freeze", hz.pipe_freeze, 1'b0);
      chk("rw_rst_pc_write", hz.pc_write, 1'b1);
      chk("rw_rst_timeout_out", hz.mem_timeout, 1'b0);
      next_cycle();
      rst = 1'b0;
      idle_inputs();
      #1;
      chk("rw_state", dut.state, RUN);
      chk("rw_freeze", hz.pipe_freeze, 1'b0);
      chk("rw_pc_write", hz.pc_write, 1'b1);
      chk("rw_ifid_write", hz.ifid_write, 1'b1);
      chk("rw_timeout_cleared", hz.mem_timeout, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
      chk("rw_stall_cycles", hz.stall_cycles, 32'd0);
      chk("rw_flush_count", hz.flush_count, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
